// File: rtl/innerproduct_seq_ctrl.sv
// -----------------------------------------------------------------------------
// innerproduct_seq_ctrl
//
// Computes hprime = sum over i of x[i] * theta[i] for N_FEAT features with one
// shared multiply-accumulate unit. Features come from a line-buffer window
// through a combinational random-access read port. Weights come from a
// synchronous theta ROM that has one cycle of read latency.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid until that edge.
// The consumer may raise or drop ready at any time. The start side is
// in_valid/in_ready. The result side is out_valid/out_ready, and hprime is
// held stable while out_valid is high.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   start request / controller idle
//   x_idx, x_data         feature index out, feature value in (same cycle)
//   theta_addr            theta ROM address
//   theta_data            ROM data, valid one cycle after theta_addr
//   out_valid / out_ready result handshake
//   hprime                accumulated inner product
//   busy                  controller is not idle
//
// Optional feature: define INNERPRODUCT_SAT_EN to make the accumulator
// saturate at 2^TW-1 instead of wrapping modulo 2^TW.
// -----------------------------------------------------------------------------
module innerproduct_seq_ctrl #(
    parameter int N_FEAT = 81,
    parameter int XW     = 7,
    parameter int TW     = 32,
    parameter int AW     = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] x_idx,
    input  logic [XW-1:0] x_data,
    output logic [AW-1:0] theta_addr,
    input  logic [TW-1:0] theta_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] hprime,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_FEAT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [XW-1:0] x_q, x_d;
    logic          pv_q, pv_d;       // x_q and theta_data form a valid pair
    logic [TW-1:0] acc_q, acc_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

`ifdef INNERPRODUCT_SAT_EN
    logic             sat_q, sat_d;
    logic [XW+TW-1:0] prod_full;
    logic [TW:0]      sum_full;

    assign prod_full = {{TW{1'b0}}, x_q} * {{XW{1'b0}}, theta_data};
    assign sum_full  = {1'b0, acc_q} + {1'b0, prod_full[TW-1:0]};
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        pv_d    = 1'b0;
        acc_d   = acc_q;
`ifdef INNERPRODUCT_SAT_EN
        sat_d   = sat_q;
`endif

        // Retire the pair fetched during the previous cycle.
        if (pv_q) begin
`ifdef INNERPRODUCT_SAT_EN
            // Once saturated, the accumulator stays clamped until the next start.
            if (sat_q || (|prod_full[XW+TW-1:TW]) || sum_full[TW]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = sum_full[TW-1:0];
            end
`else
            acc_d = acc_q + TW'({{TW{1'b0}}, x_q} * {{XW{1'b0}}, theta_data});
`endif
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    idx_d   = '0;
                    acc_d   = '0;
`ifdef INNERPRODUCT_SAT_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                // x is captured on the same edge the ROM registers theta,
                // so both halves of the pair line up one cycle after issue.
                x_d  = x_data;
                pv_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;        // keeps the address outputs at 0 outside RUN
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            pv_q        <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef INNERPRODUCT_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            pv_q        <= pv_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef INNERPRODUCT_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign hprime     = acc_q;
    assign x_idx      = idx_q;
    assign theta_addr = idx_q;

endmodule

// File: tb/tb_innerproduct_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for innerproduct_seq_ctrl. A feature window and a synchronous
// theta ROM are modelled here. An accept monitor pushes the model result for
// each start, and a result monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_innerproduct_seq_ctrl;

    localparam int N_FEAT = 81;
    localparam int XW     = 7;
    localparam int TW     = 32;
    localparam int AW     = 7;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] x_idx;
    logic [XW-1:0] x_data;
    logic [AW-1:0] theta_addr;
    logic [TW-1:0] theta_data;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] hprime;
    logic          busy;

    logic [XW-1:0] x_mem  [0:127];
    logic [TW-1:0] th_mem [0:127];

    logic [TW-1:0] exp_q[$];
    int            n_cmp;
    int            n_err;
    int            cyc;
    int            n_acc;

    innerproduct_seq_ctrl #(
        .N_FEAT(N_FEAT), .XW(XW), .TW(TW), .AW(AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_idx      (x_idx),
        .x_data     (x_data),
        .theta_addr (theta_addr),
        .theta_data (theta_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .hprime     (hprime),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- window and ROM models ----------------
    assign x_data = x_mem[x_idx];

    always @(posedge clk) theta_data <= th_mem[theta_addr];

    // ---------------- reference model ----------------
    function automatic logic [TW-1:0] model();
        logic [TW:0]      s;
        logic [XW+TW-1:0] p;
        logic             sat;
        s   = '0;
        sat = 1'b0;
        for (int i = 0; i < N_FEAT; i++) begin
            p = {{TW{1'b0}}, x_mem[i]} * {{XW{1'b0}}, th_mem[i]};
`ifdef INNERPRODUCT_SAT_EN
            s = {1'b0, s[TW-1:0]} + {1'b0, p[TW-1:0]};
            if (p[XW+TW-1:TW] != 0 || s[TW]) sat = 1'b1;
`else
            s = {1'b0, s[TW-1:0] + p[TW-1:0]};
`endif
        end
        return sat ? '1 : s[TW-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model());
            n_acc++;
        end
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("hprime", hprime, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill(input int mode);
        for (int i = 0; i < 128; i++) begin
            case (mode)
                0: begin x_mem[i] = 7'd1;   th_mem[i] = 32'(i); end
                1: begin x_mem[i] = 7'd127; th_mem[i] = 32'd1; end
                2: begin x_mem[i] = 7'd127; th_mem[i] = 32'hFFFF_FFFF; end
                default: begin
                    x_mem[i]  = 7'($urandom_range(0, 127));
                    th_mem[i] = $urandom_range(0, 32'h00FF_FFFF);
                end
            endcase
        end
    endtask

    // Starts one computation from IDLE (called at a negedge) and checks the
    // index sequence and result timing. Leaves out_valid up if out_ready=0.
    task automatic run_one();
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < N_FEAT; i++) begin
            @(negedge clk);
            check("x_idx", 32'(x_idx), 32'(i));
            check("theta_addr", 32'(theta_addr), 32'(i));
            check("in_ready_run", 32'(in_ready), 32'd0);
            check("out_valid_run", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("drain_x_idx", 32'(x_idx), 32'd0);
        check("drain_theta_addr", 32'(theta_addr), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_out_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        if (out_ready) begin
            @(negedge clk);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_in_ready", 32'(in_ready), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t_rise;
        int a_mark;
        n_cmp     = 0;
        n_err     = 0;
        cyc       = 0;
        n_acc     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fill(0);

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hprime", hprime, 32'd0);
        check("rst_x_idx", 32'(x_idx), 32'd0);
        check("rst_theta_addr", 32'(theta_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // x=1, theta=i: sum 0..80 = 3240
        check("model_ramp", model(), 32'd3240);
        run_one();

        // x=127, theta=1 with the result held back for 10 cycles
        fill(1);
        out_ready = 1'b0;
        run_one();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_hprime", hprime, 32'd10287);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);

        // Large weights: wrap or saturate depending on build
        fill(2);
`ifdef INNERPRODUCT_SAT_EN
        check("model_big", model(), 32'hFFFF_FFFF);
`else
        check("model_big", model(), 32'hFFFF_D7D1);
`endif
        run_one();

        // Asynchronous abort in the middle of RUN
        fill(3);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (x_idx == 7'd40) break;
        end
        check("reach_idx40", 32'(x_idx), 32'd40);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hprime", hprime, 32'd0);
        check("abort_x_idx", 32'(x_idx), 32'd0);
        check("abort_theta_addr", 32'(theta_addr), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_one();

        // Back-to-back starts: one result every N_FEAT+3 cycles
        fill(3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            check("b2b_out_valid", 32'(out_valid), 32'd1);
            if (r > 0) begin
                check("b2b_period", 32'(cyc - t_rise), 32'(N_FEAT + 3));
                check("b2b_one_accept", 32'(n_acc - a_mark), 32'd1);
            end
            t_rise = cyc;
            a_mark = n_acc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
